// File: rtl/dma_pkg.sv
// dma_pkg: shared encodings for the DMA burst controller.
// FSM state codes, config register map and control/status bits.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_REQ         = 3'd1,
    S_BEGIN       = 3'd2,
    S_RD_DATA     = 3'd3,
    S_WR_PREFETCH = 3'd4,
    S_WR_DATA     = 3'd5,
    S_WR_END      = 3'd6
  } dma_state_e;

  localparam logic [2:0] CFG_BUS_ADDR = 3'd0;
  localparam logic [2:0] CFG_MEM_ADDR = 3'd1;
  localparam logic [2:0] CFG_BLOCK    = 3'd2;
  localparam logic [2:0] CFG_BURST    = 3'd3;
  localparam logic [2:0] CFG_CONTROL  = 3'd4;
  localparam logic [2:0] CFG_STATUS   = 3'd5;

  localparam int CTRL_START_RD = 0;
  localparam int CTRL_START_WR = 1;
  localparam int ST_BUSY       = 0;
  localparam int ST_ERROR      = 1;

endpackage

// File: rtl/dma_burst_sizer.sv
// dma_burst_sizer: length of the next bus burst and
// last-word flag for the burst in flight.
module dma_burst_sizer #(
  parameter int BLOCK_W = 10
) (
  input  logic [BLOCK_W-1:0] remaining_i,
  input  logic [7:0]         burstSize_i,
  input  logic [BLOCK_W-1:0] beats_i,
  output logic [BLOCK_W-1:0] burstLen_o,
  output logic               lastWord_o
);

  localparam int LW = BLOCK_W + 1;

  logic [LW-1:0] maxLen;

  // burst = min(remaining, burstSize+1)
  always_comb begin
    maxLen = LW'(burstSize_i) + LW'(1);
    if ({1'b0, remaining_i} < maxLen) begin
      burstLen_o = remaining_i;
    end else begin
      burstLen_o = maxLen[BLOCK_W-1:0];
    end
    lastWord_o = (beats_i == BLOCK_W'(1));
  end

endmodule

// File: rtl/dma_burst_controller.sv
// dma_burst_controller: moves blocks between the system bus
// and SSRAM port B as a sequence of arbitrated bursts.
module dma_burst_controller
  import dma_pkg::*;
#(
  parameter int MEM_ADDR_W = 9,
  parameter int BLOCK_W    = 10
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  cfgWrite,
  input  logic [2:0]            cfgSelect,
  input  logic [31:0]           cfgWriteData,
  output logic [31:0]           cfgReadData,
  output logic                  requestBus,
  input  logic                  busGrant,
  output logic                  beginTransOut,
  output logic [31:0]           addressDataOut,
  output logic [7:0]            burstSizeOut,
  output logic                  readNotWriteOut,
  output logic                  dataValidOut,
  output logic                  endTransOut,
  input  logic                  busyIn,
  input  logic [31:0]           addressDataIn,
  input  logic                  dataValidIn,
  input  logic                  endTransIn,
  input  logic                  busErrorIn,
  output logic [MEM_ADDR_W-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [31:0]           memWriteData,
  input  logic [31:0]           memReadData
);

  localparam logic [BLOCK_W-1:0]    BLK_ONE = BLOCK_W'(1);
  localparam logic [MEM_ADDR_W-1:0] MEM_ONE = MEM_ADDR_W'(1);

  dma_state_e state_q, state_d;

  logic [31:0]           busAddr_q, busAddr_d;
  logic [MEM_ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [BLOCK_W-1:0]    blockSize_q, blockSize_d;
  logic [7:0]            burstSize_q, burstSize_d;
  logic                  error_q, error_d;
  logic                  isWrite_q, isWrite_d;
  logic [BLOCK_W-1:0]    remaining_q, remaining_d;
  logic [BLOCK_W-1:0]    beats_q, beats_d;
  logic [31:0]           curBus_q, curBus_d;
  logic [MEM_ADDR_W-1:0] curMem_q, curMem_d;
  logic [31:0]           hold_q, hold_d;
  logic                  holdValid_q, holdValid_d;

  logic [BLOCK_W-1:0] burstLen;
  logic               lastWord;
  logic               busy;
  logic               startRd;
  logic               startWr;
  logic [31:0]        wrWord;

  assign busy = (state_q != S_IDLE);

  dma_burst_sizer #(
    .BLOCK_W(BLOCK_W)
  ) u_sizer (
    .remaining_i(remaining_q),
    .burstSize_i(burstSize_q),
    .beats_i    (beats_q),
    .burstLen_o (burstLen),
    .lastWord_o (lastWord)
  );

  // state and datapath registers
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      busAddr_q   <= '0;
      memAddr_q   <= '0;
      blockSize_q <= '0;
      burstSize_q <= '0;
      error_q     <= 1'b0;
      isWrite_q   <= 1'b0;
      remaining_q <= '0;
      beats_q     <= '0;
      curBus_q    <= '0;
      curMem_q    <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busAddr_q   <= busAddr_d;
      memAddr_q   <= memAddr_d;
      blockSize_q <= blockSize_d;
      burstSize_q <= burstSize_d;
      error_q     <= error_d;
      isWrite_q   <= isWrite_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      curBus_q    <= curBus_d;
      curMem_q    <= curMem_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
    end
  end

  // next state, datapath updates and bus/SSRAM outputs
  always_comb begin
    state_d     = state_q;
    busAddr_d   = busAddr_q;
    memAddr_d   = memAddr_q;
    blockSize_d = blockSize_q;
    burstSize_d = burstSize_q;
    error_d     = error_q;
    isWrite_d   = isWrite_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    curBus_d    = curBus_q;
    curMem_d    = curMem_q;
    hold_d      = hold_q;
    holdValid_d = holdValid_q;

    requestBus      = 1'b0;
    beginTransOut   = 1'b0;
    addressDataOut  = '0;
    burstSizeOut    = '0;
    readNotWriteOut = 1'b0;
    dataValidOut    = 1'b0;
    endTransOut     = 1'b0;
    memAddress      = '0;
    memWriteEnable  = 1'b0;
    memWriteData    = '0;

    startRd = cfgWriteData[CTRL_START_RD];
    startWr = cfgWriteData[CTRL_START_WR];
    // a stalled word lives in hold_q since SSRAM has moved on
    wrWord  = holdValid_q ? hold_q : memReadData;

    unique case (state_q)
      S_IDLE: begin
        if (cfgWrite) begin
          case (cfgSelect)
            CFG_BUS_ADDR: busAddr_d   = cfgWriteData;
            CFG_MEM_ADDR: memAddr_d   = cfgWriteData[MEM_ADDR_W-1:0];
            CFG_BLOCK:    blockSize_d = cfgWriteData[BLOCK_W-1:0];
            CFG_BURST:    burstSize_d = cfgWriteData[7:0];
            CFG_CONTROL: begin
              if ((startRd ^ startWr) && (blockSize_q != '0)) begin
                error_d     = 1'b0;
                isWrite_d   = startWr;
                remaining_d = blockSize_q;
                curBus_d    = busAddr_q;
                curMem_d    = memAddr_q;
                state_d     = S_REQ;
              end
            end
            default: ;
          endcase
        end
      end
      S_REQ: begin
        requestBus = 1'b1;
        if (busGrant) begin
          beats_d = burstLen;
          state_d = S_BEGIN;
        end
      end
      S_BEGIN: begin
        beginTransOut   = 1'b1;
        addressDataOut  = curBus_q;
        burstSizeOut    = 8'(beats_q - BLK_ONE);
        readNotWriteOut = !isWrite_q;
        state_d = isWrite_q ? S_WR_PREFETCH : S_RD_DATA;
      end
      S_RD_DATA: begin
        memAddress = curMem_q;
        if (dataValidIn && (beats_q != '0)) begin
          memWriteEnable = 1'b1;
          memWriteData   = addressDataIn;
          curMem_d    = curMem_q + MEM_ONE;
          curBus_d    = curBus_q + 32'd4;
          remaining_d = remaining_q - BLK_ONE;
          beats_d     = beats_q - BLK_ONE;
        end
        if (endTransIn) begin
          state_d = (remaining_d != '0) ? S_REQ : S_IDLE;
        end
      end
      S_WR_PREFETCH: begin
        memAddress  = curMem_q;
        holdValid_d = 1'b0;
        state_d     = S_WR_DATA;
      end
      S_WR_DATA: begin
        // read one word ahead so the next word is ready on accept
        memAddress     = curMem_q + MEM_ONE;
        dataValidOut   = 1'b1;
        addressDataOut = wrWord;
        if (busyIn) begin
          if (!holdValid_q) begin
            hold_d      = memReadData;
            holdValid_d = 1'b1;
          end
        end else begin
          holdValid_d = 1'b0;
          curMem_d    = curMem_q + MEM_ONE;
          curBus_d    = curBus_q + 32'd4;
          remaining_d = remaining_q - BLK_ONE;
          beats_d     = beats_q - BLK_ONE;
          if (lastWord) begin
            state_d = S_WR_END;
          end
        end
      end
      S_WR_END: begin
        endTransOut = 1'b1;
        state_d = (remaining_q != '0) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // bus error aborts; counters freeze for post-mortem reads
    if (busy && busErrorIn) begin
      state_d        = S_IDLE;
      error_d        = 1'b1;
      remaining_d    = remaining_q;
      beats_d        = beats_q;
      curBus_d       = curBus_q;
      curMem_d       = curMem_q;
      holdValid_d    = 1'b0;
      memWriteEnable = 1'b0;
    end
  end

  // config readback; control slot shows words still to move
  always_comb begin
    cfgReadData = '0;
    case (cfgSelect)
      CFG_BUS_ADDR: cfgReadData = busAddr_q;
      CFG_MEM_ADDR: cfgReadData = 32'(memAddr_q);
      CFG_BLOCK:    cfgReadData = 32'(blockSize_q);
      CFG_BURST:    cfgReadData = 32'(burstSize_q);
      CFG_CONTROL:  cfgReadData = 32'(remaining_q);
      CFG_STATUS: begin
        cfgReadData[ST_BUSY]  = busy;
        cfgReadData[ST_ERROR] = error_q;
      end
      default: ;
    endcase
  end

endmodule
